// File: rtl/instr_fetch.sv
// Instruction fetch unit: IDLE/FETCH/LOAD/EXEC sequencer that reads one program word
// per instruction and holds it for decode, with stall, conditional skip and jump redirect.
module instr_fetch #(
    parameter int unsigned AW = 13,
    parameter int unsigned IW = 8
) (
    input  logic          clk,
    input  logic          reset,
    output logic [AW-1:0] prog_addr,
    output logic          prog_rd,
    input  logic [IW-1:0] prog_data,
    output logic [IW-1:0] inst_reg,
    output logic          inst_valid,
    output logic [AW-1:0] counter,
    input  logic          stall,
    input  logic          skip,
    input  logic          jump,
    input  logic [AW-1:0] jump_addr
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        LOAD  = 2'd2,
        EXEC  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic          skip_pend_q, skip_pend_d;
    logic [IW-1:0] inst_q, inst_d;
    logic [AW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            pc_q        <= '0;
            skip_pend_q <= 1'b0;
            inst_q      <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            skip_pend_q <= skip_pend_d;
            inst_q      <= inst_d;
            cnt_q       <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        skip_pend_d = skip_pend_q;
        inst_d      = inst_q;
        cnt_d       = cnt_q;
        case (state_q)
            IDLE:  state_d = FETCH;
            FETCH: state_d = LOAD;
            LOAD: begin
                pc_d = pc_q + AW'(1);
                // A pending skip swallows this word and refetches at the next address.
                if (skip_pend_q) begin
                    skip_pend_d = 1'b0;
                    state_d     = FETCH;
                end else begin
                    inst_d  = prog_data;
                    cnt_d   = pc_q;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (!stall) begin
                    state_d = FETCH;
                    if (jump) begin
                        pc_d = jump_addr;
                    end else if (skip) begin
                        skip_pend_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decode straight from registered state so reset clears them without a clock.
    assign prog_rd    = (state_q == FETCH);
    assign inst_valid = (state_q == EXEC);
    assign prog_addr  = pc_q;
    assign inst_reg   = inst_q;
    assign counter    = cnt_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: per-cycle vector table plus directed reset sequences.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic [12:0] prog_addr;
    logic        prog_rd;
    logic [7:0]  prog_data = 8'h00;
    logic [7:0]  inst_reg;
    logic        inst_valid;
    logic [12:0] counter;
    logic        stall = 1'b0;
    logic        skip = 1'b0;
    logic        jump = 1'b0;
    logic [12:0] jump_addr = 13'h0;

    int tests = 0;
    int failed = 0;

    logic [7:0] mem [0:8191];

    instr_fetch #(.AW(13), .IW(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .prog_addr (prog_addr),
        .prog_rd   (prog_rd),
        .prog_data (prog_data),
        .inst_reg  (inst_reg),
        .inst_valid(inst_valid),
        .counter   (counter),
        .stall     (stall),
        .skip      (skip),
        .jump      (jump),
        .jump_addr (jump_addr)
    );

    always #5 clk = ~clk;

    // Synchronous program memory: word for the address of a prog_rd cycle appears next cycle.
    always @(posedge clk) begin
        if (prog_rd) prog_data <= mem[prog_addr];
    end

    typedef struct {
        logic        stall;
        logic        skip;
        logic        jump;
        logic [12:0] jaddr;
        logic        rd;
        logic [12:0] addr;
        logic        valid;
        logic [7:0]  ir;
        logic [12:0] cnt;
    } vec_t;

    localparam int NV = 29;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic st, input logic sk, input logic jp,
                                input logic [12:0] ja, input logic rd,
                                input logic [12:0] ad, input logic vl,
                                input logic [7:0] ir, input logic [12:0] cn);
        vec_t v;
        v.stall = st; v.skip = sk; v.jump = jp; v.jaddr = ja;
        v.rd = rd; v.addr = ad; v.valid = vl; v.ir = ir; v.cnt = cn;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic rd, input logic [12:0] ad,
                            input logic vl, input logic [7:0] ir, input logic [12:0] cn);
        chk({tag, ".prog_rd"},    32'(prog_rd),    32'(rd));
        chk({tag, ".prog_addr"},  32'(prog_addr),  32'(ad));
        chk({tag, ".inst_valid"}, 32'(inst_valid), 32'(vl));
        chk({tag, ".inst_reg"},   32'(inst_reg),   32'(ir));
        chk({tag, ".counter"},    32'(counter),    32'(cn));
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!inst_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
    endtask

    int n;

    initial begin
        for (int i = 0; i < 8192; i++) mem[i] = 8'(i + 'h40);
        mem[0]       = 8'h1D;
        mem[1]       = 8'h1F;
        mem[2]       = 8'h39;
        mem[13'h100] = 8'hA5;
        mem[13'h1FFF] = 8'hC3;

        //                stall skip jump jaddr     rd addr     vld ir     cnt
        vecs[0]  = mk(0, 0, 0, 13'h0,    0, 13'h0,    0, 8'h00, 13'h0);    // IDLE
        vecs[1]  = mk(1, 1, 1, 13'h55,   1, 13'h0,    0, 8'h00, 13'h0);    // FETCH, inputs ignored
        vecs[2]  = mk(0, 0, 0, 13'h0,    0, 13'h0,    0, 8'h00, 13'h0);    // LOAD
        vecs[3]  = mk(0, 0, 0, 13'h0,    0, 13'h1,    1, 8'h1D, 13'h0);    // EXEC consume
        vecs[4]  = mk(0, 0, 0, 13'h0,    1, 13'h1,    0, 8'h1D, 13'h0);
        vecs[5]  = mk(0, 0, 0, 13'h0,    0, 13'h1,    0, 8'h1D, 13'h0);
        vecs[6]  = mk(1, 0, 0, 13'h0,    0, 13'h2,    1, 8'h1F, 13'h1);    // stall x4
        vecs[7]  = mk(1, 0, 1, 13'h80,   0, 13'h2,    1, 8'h1F, 13'h1);
        vecs[8]  = mk(1, 1, 0, 13'h0,    0, 13'h2,    1, 8'h1F, 13'h1);
        vecs[9]  = mk(1, 0, 0, 13'h0,    0, 13'h2,    1, 8'h1F, 13'h1);
        vecs[10] = mk(0, 0, 0, 13'h0,    0, 13'h2,    1, 8'h1F, 13'h1);    // released
        vecs[11] = mk(0, 0, 0, 13'h0,    1, 13'h2,    0, 8'h1F, 13'h1);
        vecs[12] = mk(0, 0, 0, 13'h0,    0, 13'h2,    0, 8'h1F, 13'h1);
        vecs[13] = mk(0, 1, 1, 13'h100,  0, 13'h3,    1, 8'h39, 13'h2);    // jump beats skip
        vecs[14] = mk(0, 0, 1, 13'h777,  1, 13'h100,  0, 8'h39, 13'h2);
        vecs[15] = mk(0, 0, 0, 13'h0,    0, 13'h100,  0, 8'h39, 13'h2);
        vecs[16] = mk(0, 0, 1, 13'h1FFF, 0, 13'h101,  1, 8'hA5, 13'h100);
        vecs[17] = mk(0, 0, 0, 13'h0,    1, 13'h1FFF, 0, 8'hA5, 13'h100);
        vecs[18] = mk(0, 0, 0, 13'h0,    0, 13'h1FFF, 0, 8'hA5, 13'h100);
        vecs[19] = mk(0, 0, 0, 13'h0,    0, 13'h0,    1, 8'hC3, 13'h1FFF); // wrapped pc
        vecs[20] = mk(0, 0, 0, 13'h0,    1, 13'h0,    0, 8'hC3, 13'h1FFF);
        vecs[21] = mk(0, 0, 0, 13'h0,    0, 13'h0,    0, 8'hC3, 13'h1FFF);
        vecs[22] = mk(0, 1, 0, 13'h0,    0, 13'h1,    1, 8'h1D, 13'h0);    // skip
        vecs[23] = mk(0, 0, 0, 13'h0,    1, 13'h1,    0, 8'h1D, 13'h0);
        vecs[24] = mk(1, 0, 1, 13'h55,   0, 13'h1,    0, 8'h1D, 13'h0);    // discard word 1
        vecs[25] = mk(0, 0, 0, 13'h0,    1, 13'h2,    0, 8'h1D, 13'h0);
        vecs[26] = mk(0, 0, 0, 13'h0,    0, 13'h2,    0, 8'h1D, 13'h0);
        vecs[27] = mk(0, 0, 0, 13'h0,    0, 13'h3,    1, 8'h39, 13'h2);
        vecs[28] = mk(0, 0, 0, 13'h0,    1, 13'h3,    0, 8'h39, 13'h2);

        reset = 1'b1;
        #1;
        chk_outs("por", 0, 13'h0, 0, 8'h00, 13'h0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            chk_outs($sformatf("vec%0d", i), vecs[i].rd, vecs[i].addr,
                     vecs[i].valid, vecs[i].ir, vecs[i].cnt);
            stall     = vecs[i].stall;
            skip      = vecs[i].skip;
            jump      = vecs[i].jump;
            jump_addr = vecs[i].jaddr;
            @(negedge clk);
        end

        // Now in LOAD of address 3; hold the following EXEC with stall, then reset mid-cycle.
        stall = 1'b1;
        @(negedge clk);
        chk_outs("exec3", 0, 13'h4, 1, 8'h43, 13'h3);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk_outs("async_exec", 0, 13'h0, 0, 8'h00, 13'h0);
        @(negedge clk);
        reset = 1'b0;
        stall = 1'b0;
        chk_outs("rst_idle", 0, 13'h0, 0, 8'h00, 13'h0);
        @(posedge clk);
        #1;
        chk_outs("rst_fetch", 1, 13'h0, 0, 8'h00, 13'h0);
        @(negedge clk);
        wait_valid(n);
        chk("wait_valid_a", 32'(n), 32'd2);
        chk_outs("restart_a", 0, 13'h1, 1, 8'h1D, 13'h0);

        // Consume, then reset while the fetch of address 1 is in flight.
        @(negedge clk);
        chk_outs("fetch1", 1, 13'h1, 0, 8'h1D, 13'h0);
        #1 reset = 1'b1;
        #1;
        chk_outs("async_fetch", 0, 13'h0, 0, 8'h00, 13'h0);
        @(negedge clk);
        reset = 1'b0;
        wait_valid(n);
        chk("wait_valid_b", 32'(n), 32'd3);
        chk_outs("restart_b", 0, 13'h1, 1, 8'h1D, 13'h0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
